// File: rtl/revaluate_stream.sv
// Streaming Keccak chi stage: applies chi to each 5-bit row of a 25-bit slice,
// buffers results in a small FIFO and tracks slice position within a frame.
module revaluate_stream #(
  parameter int SLICES = 64,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_data,
  output logic        out_last,
  output logic [5:0]  slice_count,
  output logic        frame_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [24:0] chi(input logic [24:0] s);
    logic [24:0] r;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[5*y+x] = s[5*y+x] ^ (~s[5*y+(x+1)%5] & s[5*y+(x+2)%5]);
      end
    end
    return r;
  endfunction

  logic [24:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [5:0]    cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic          full, empty, push, pop;

  assign full        = (occ_q == OW'(DEPTH));
  assign empty       = (occ_q == '0);
  assign in_ready    = !full && !rst;
  assign out_valid   = !empty;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  // No bypass path: an empty FIFO presents zero rather than stale storage.
  assign out_data    = empty ? '0 : mem_q[rptr_q];
  assign out_last    = out_valid && (cnt_q == 6'(SLICES - 1));
  assign slice_count = cnt_q;
  assign frame_done  = (state_q == DONE);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    occ_d   = occ_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    if (pop) cnt_d = out_last ? 6'd0 : cnt_q + 6'd1;
    case (state_q)
      IDLE:    if (pop) state_d = RUN;
      RUN:     if (pop && out_last) state_d = DONE;
      DONE:    state_d = pop ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Storage is data-only; validity comes from the occupancy counter.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= chi(in_data);
  end
endmodule

// File: tb/tb_revaluate_stream.sv
// Directed bench for revaluate_stream with a queue-based reference of the FIFO and frame counter.
module tb_revaluate_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] out_data;
  logic        out_last;
  logic [5:0]  slice_count;
  logic        frame_done;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int n_last = 0;
  logic [24:0] exp_q[$];
  int cnt_exp = 0;
  bit done_exp = 1'b0;

  revaluate_stream #(.SLICES(64), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .slice_count(slice_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Row-rotation form of chi: row ^ (~rot1(row) & rot2(row)).
  function automatic logic [24:0] chi_ref(input logic [24:0] s);
    logic [24:0] o;
    logic [4:0]  r, r1, r2;
    o = '0;
    for (int y = 0; y < 5; y++) begin
      r  = s[5*y +: 5];
      r1 = {r[0], r[4:1]};
      r2 = {r[1:0], r[4:2]};
      o[5*y +: 5] = r ^ (~r1 & r2);
    end
    return o;
  endfunction

  function automatic logic [24:0] pat(input int i);
    logic [31:0] t;
    t = i * 32'h0012_3457 + 32'h015A_A5C3;
    return t[24:0];
  endfunction

  task automatic step(input logic iv, input logic [24:0] id, input logic ordy);
    bit push, pop, dn;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, exp_q.size() < 4);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
    chk("out_last", out_last, (exp_q.size() != 0) && (cnt_exp == 63));
    chk("slice_count", slice_count, cnt_exp);
    chk("frame_done", frame_done, done_exp);
    if (frame_done) n_done++;
    if (out_last)   n_last++;
    push = iv && (exp_q.size() < 4);
    pop  = ordy && (exp_q.size() != 0);
    dn   = pop && (cnt_exp == 63);
    if (pop) begin
      void'(exp_q.pop_front());
      cnt_exp = (cnt_exp == 63) ? 0 : cnt_exp + 1;
    end
    if (push) exp_q.push_back(chi_ref(id));
    done_exp = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = pat(999);
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_slice_count", slice_count, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_last", out_last, 0);
    exp_q.delete();
    cnt_exp  = 0;
    done_exp = 1'b0;
    n_done   = 0;
    n_last   = 0;
  endtask

  task automatic chi_vec(input logic [24:0] v, input logic [24:0] e);
    step(1'b1, v, 1'b1);
    chk("chi_valid", out_valid, 1);
    chk("chi_value", out_data, e);
    step(1'b0, '0, 1'b1);
  endtask

  initial begin
    // Reset values while rst is held
    @(posedge clk);
    #1;
    chk("init_in_ready", in_ready, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data", out_data, 0);
    chk("init_out_last", out_last, 0);
    chk("init_slice_count", slice_count, 0);
    chk("init_frame_done", frame_done, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Hand-computed chi vectors through an empty FIFO
    chi_vec(25'h0000000, 25'h0000000);
    chi_vec(25'h1FFFFFF, 25'h1FFFFFF);
    chi_vec(25'h0000001, 25'h0000009);
    chi_vec(25'h0000004, 25'h0000005);

    // Backpressure: fill, reject a 5th, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, pat(100 + i), 1'b0);
    chk("bp_full_ready", in_ready, 0);
    step(1'b1, pat(104), 1'b0);
    chk("bp_hold_data", out_data, chi_ref(pat(100)));
    step(1'b1, pat(104), 1'b1);
    chk("bp_ready_after_pop", in_ready, 1);
    step(1'b1, pat(104), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    chk("bp_count", slice_count, 5);

    // One full frame at one slice per cycle
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, pat(i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    chk("frame_done_pulses", n_done, 1);
    chk("frame_last_pulses", n_last, 1);
    chk("frame_end_count", slice_count, 0);

    // Back-to-back frames
    do_reset();
    for (int i = 0; i < 128; i++) step(1'b1, pat(200 + i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    chk("b2b_done_pulses", n_done, 2);
    chk("b2b_last_pulses", n_last, 2);

    // Simultaneous push and pop at occupancy 2
    do_reset();
    step(1'b1, pat(400), 1'b0);
    step(1'b1, pat(401), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, pat(402 + i), 1'b1);
    chk("occ2_pending", exp_q.size(), 2);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    chk("occ2_drained", out_valid, 0);
    chk("occ2_count", slice_count, 12);

    // Reset after 30 slices, then a full frame
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, pat(500 + i), 1'b1);
    chk("mid_count", slice_count, 29);
    do_reset();
    step(1'b0, '0, 1'b0);
    chk("mid_no_done", n_done, 0);
    for (int i = 0; i < 64; i++) step(1'b1, pat(600 + i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    chk("mid_frame_done", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
